// File: rtl/step_pulse_gen.sv
// step_pulse_gen: one-axis STEP/DIR pulse train generator.
// Turns a latched timing set (N, nn, t0, tna, delta) into a trapezoidal
// (or triangular) step profile: accelerate from t0 toward tna, cruise,
// then decelerate back toward t0, emitting exactly N steps.
//
// Ports:
//   clk, reset (async, active-low)
//   start, params_valid   move request / parameter set valid
//   params[0:4]           N, nn, t0, tna, delta (32-bit unsigned)
//   dir_in, abort         direction (latched on accept), stop after current step
//   set_pos, pos_value    position preload (only with STEP_POSITION_EN)
//   step, dir             driver pins
//   busy, done            move in progress / one-cycle completion pulse
//   steps_done, position  step count of current/last move, absolute position
//
// Optional feature: define STEP_POSITION_EN to build the position counter;
// otherwise position is tied to zero.
module step_pulse_gen #(
    parameter int unsigned PULSE_WIDTH = 50,
    parameter int unsigned MIN_PERIOD  = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               params_valid,
    input  logic [31:0]        params [0:4],
    input  logic               dir_in,
    input  logic               abort,
    input  logic               set_pos,
    input  logic [31:0]        pos_value,
    output logic               step,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic [31:0]        steps_done,
    output logic signed [31:0] position
);
    localparam int unsigned W = 32;
    localparam logic [W-1:0] PW   = W'(PULSE_WIDTH);
    localparam logic [W-1:0] MINP = W'(MIN_PERIOD);

    typedef enum logic [2:0] {IDLE, LOAD, HI, LO, DONE, WAIT_REL} state_t;
    typedef enum logic [1:0] {PH_ACCEL, PH_CRUISE, PH_DECEL} phase_t;

    state_t state, state_d;
    phase_t phase, phase_n;

    logic [W-1:0] n_r, nn_r, t0_r, tna_r, delta_r;
    logic [W-1:0] period, cnt, grp, accel_steps;
    logic         abort_seen;

    logic         accept_c, step_end_c;
    logic [W-1:0] t0_eff, floor_p, sd_inc, acc_inc, grp_inc, grp_n, period_n, dec;
    logic [W:0]   sum;
    logic         grp_wrap;

    // Effective period limits after applying the global floor
    assign t0_eff  = (t0_r  > MINP) ? t0_r  : MINP;
    assign floor_p = (tna_r > MINP) ? tna_r : MINP;
    assign accept_c = (state == IDLE) && start && params_valid;

    // Next-state logic
    always_comb begin
        state_d    = state;
        step_end_c = 1'b0;
        case (state)
            IDLE:     if (accept_c) state_d = (params[0] == '0) ? DONE : LOAD;
            LOAD:     state_d = HI;
            HI:       if (cnt == PW - W'(1)) state_d = LO;
            LO: begin
                if (cnt == period - PW - W'(1)) begin
                    step_end_c = 1'b1;
                    state_d = (sd_inc == n_r || abort_seen || abort) ? DONE : HI;
                end
            end
            DONE:     state_d = WAIT_REL;
            WAIT_REL: if (!start) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Profile update applied at the end of each completed step
    always_comb begin
        sd_inc   = steps_done + W'(1);
        acc_inc  = (phase == PH_ACCEL) ? accel_steps + W'(1) : accel_steps;
        grp_inc  = grp + W'(1);
        grp_wrap = (nn_r != '0) && (grp_inc == nn_r);
        grp_n    = grp_wrap ? '0 : grp_inc;
        period_n = period;
        phase_n  = phase;
        dec      = (period > delta_r) ? period - delta_r : '0;
        sum      = {1'b0, period} + {1'b0, delta_r};
        if (grp_wrap) begin
            if (phase == PH_ACCEL) begin
                period_n = (dec > floor_p) ? dec : floor_p;
                if (period_n == floor_p) phase_n = PH_CRUISE;
            end else if (phase == PH_DECEL) begin
                period_n = (sum > {1'b0, t0_eff}) ? t0_eff : sum[W-1:0];
            end
        end
        // Decel entry is judged after the accel update of the same step
        if (phase_n != PH_DECEL && (n_r - sd_inc) <= acc_inc) begin
            phase_n = PH_DECEL;
            grp_n   = '0;
        end
    end

    // State register and registered FSM outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            step  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            step  <= (state_d == HI);
            busy  <= (state_d == LOAD) || (state_d == HI) || (state_d == LO);
            done  <= (state_d == DONE);
        end
    end

    // Move parameters, timing counter and profile state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_r         <= '0;
            nn_r        <= '0;
            t0_r        <= '0;
            tna_r       <= '0;
            delta_r     <= '0;
            dir         <= 1'b0;
            period      <= '0;
            cnt         <= '0;
            grp         <= '0;
            accel_steps <= '0;
            steps_done  <= '0;
            phase       <= PH_CRUISE;
            abort_seen  <= 1'b0;
        end else begin
            cnt <= (state_d != state) ? '0 : cnt + W'(1);
            if (accept_c) begin
                n_r     <= params[0];
                nn_r    <= params[1];
                t0_r    <= params[2];
                tna_r   <= params[3];
                delta_r <= params[4];
                dir     <= dir_in;
                if (params[0] == '0) steps_done <= '0;
            end
            if (state == LOAD) begin
                period      <= t0_eff;
                steps_done  <= '0;
                grp         <= '0;
                accel_steps <= '0;
                phase <= (nn_r != '0 && delta_r != '0 && t0_r > tna_r) ? PH_ACCEL : PH_CRUISE;
            end
            if (step_end_c) begin
                steps_done  <= sd_inc;
                accel_steps <= acc_inc;
                grp         <= grp_n;
                period      <= period_n;
                phase       <= phase_n;
            end
            // Abort is remembered for the whole step it arrives in
            if (state_d == HI && state != HI)
                abort_seen <= 1'b0;
            else if ((state == HI || state == LO) && abort)
                abort_seen <= 1'b1;
        end
    end

`ifdef STEP_POSITION_EN
    // Absolute position; a preload wins over a simultaneous step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            position <= '0;
        else if (set_pos)
            position <= $signed(pos_value);
        else if (step_end_c)
            position <= dir ? position + 32'sd1 : position - 32'sd1;
    end
`else
    logic unused_pos;
    assign unused_pos = ^{set_pos, pos_value};
    assign position   = '0;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
module tb_step_pulse_gen;
    logic               clk = 1'b0;
    logic               reset, start, params_valid, dir_in, abort, set_pos;
    logic [31:0]        params [0:4];
    logic [31:0]        pos_value;
    logic               step, dir, busy, done;
    logic [31:0]        steps_done;
    logic signed [31:0] position;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rises[$];
    int widths[$];
    int exp_q[$];
    int rise_last = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int start_cyc = 0;
    bit busy_seen = 0;
    bit step_q    = 0;

    step_pulse_gen dut (
        .clk(clk), .reset(reset), .start(start), .params_valid(params_valid),
        .params(params), .dir_in(dir_in), .abort(abort), .set_pos(set_pos),
        .pos_value(pos_value), .step(step), .dir(dir), .busy(busy), .done(done),
        .steps_done(steps_done), .position(position)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse train monitor
    always @(negedge clk) begin
        if (step && !step_q) begin rises.push_back(cyc); rise_last = cyc; end
        if (!step && step_q) widths.push_back(cyc - rise_last);
        if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
        if (busy) busy_seen = 1;
        step_q = step;
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint pexp(input longint v);
`ifdef STEP_POSITION_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic push_n(input int v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Compare observed step periods against exp_q; last period ends at done
    task automatic check_periods(input string tag);
        check({tag, "_pulses"}, rises.size(), exp_q.size());
        if (rises.size() == exp_q.size() && done_cyc >= 0) begin
            for (int i = 0; i < rises.size(); i++) begin
                if (i < rises.size() - 1)
                    check($sformatf("%s_period%0d", tag, i), rises[i+1] - rises[i], exp_q[i]);
                else
                    check($sformatf("%s_period%0d", tag, i), done_cyc - rises[i], exp_q[i]);
            end
        end
    endtask

    task automatic run_move(input logic [31:0] n, input logic [31:0] nn_v,
                            input logic [31:0] t0_v, input logic [31:0] tna_v,
                            input logic [31:0] dl, input logic d,
                            input int abort_step, input int rst_step, input int budget);
        int  k;
        bit  aborted;
        rises.delete(); widths.delete(); exp_q.delete();
        done_cnt = 0; done_cyc = -1; busy_seen = 0; aborted = 0;
        @(negedge clk); #1;
        params[0] = n; params[1] = nn_v; params[2] = t0_v; params[3] = tna_v; params[4] = dl;
        params_valid = 1; dir_in = d; start = 1; start_cyc = cyc;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk); #1; k++;
            if (abort_step > 0 && !aborted && rises.size() == abort_step && step) begin
                abort = 1; aborted = 1;
            end else begin
                abort = 0;
            end
            if (abort_step > 0 && k == 3) begin
                start = 0; params_valid = 0; params[0] = 32'd5; dir_in = ~d;
            end
            if (rst_step > 0 && rises.size() == rst_step && !step) begin
                reset = 0; #1;
                check("rst_step", step, 0);
                check("rst_busy", busy, 0);
                check("rst_steps_done", steps_done, 0);
                check("rst_position", position, 0);
                @(negedge clk); #1;
                reset = 1; start = 0; params_valid = 0;
                repeat (2) @(negedge clk);
                return;
            end
        end
        check("done_seen", done_cnt > 0, 1);
        repeat (4) @(negedge clk);
        #1 start = 0; params_valid = 0; abort = 0;
        repeat (4) @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 0; start = 0; params_valid = 0; dir_in = 0; abort = 0;
        set_pos = 0; pos_value = '0;
        for (int i = 0; i < 5; i++) params[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_step", step, 0);
        check("reset_dir", dir, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_steps_done", steps_done, 0);
        check("reset_position", position, 0);
        #1 reset = 1;

        // Constant-speed move
        run_move(4, 0, 200, 200, 0, 1'b1, 0, 0, 5000);
        push_n(200, 4);
        check_periods("const");
        check("const_latency", (rises.size() > 0) ? rises[0] - start_cyc : -1, 2);
        check("const_width_cnt", widths.size(), 4);
        for (int i = 0; i < widths.size(); i++) check($sformatf("const_width%0d", i), widths[i], 50);
        check("const_done_cnt", done_cnt, 1);
        check("const_steps_done", steps_done, 4);
        check("const_position", position, pexp(4));
        check("const_dir", dir, 1);
        check("const_busy_seen", busy_seen, 1);
        check("const_busy_end", busy, 0);

        // Trapezoid
        run_move(20, 2, 1000, 400, 200, 1'b0, 0, 0, 20000);
        push_n(1000, 2); push_n(800, 2); push_n(600, 2); push_n(400, 10);
        push_n(600, 2); push_n(800, 2);
        check_periods("trap");
        check("trap_steps_done", steps_done, 20);
        check("trap_position", position, pexp(-16));
        check("trap_dir", dir, 0);

        // Triangle: too short to reach tna
        run_move(6, 2, 1000, 400, 200, 1'b0, 0, 0, 10000);
        push_n(1000, 2); push_n(800, 3); push_n(1000, 1);
        check_periods("tri");
        check("tri_steps_done", steps_done, 6);
        check("tri_position", position, pexp(-22));

        // Zero-length move
        run_move(0, 2, 1000, 400, 200, 1'b1, 0, 0, 20);
        check("zero_done_latency", (done_cyc >= 0) && (done_cyc - start_cyc <= 2), 1);
        check("zero_pulses", rises.size(), 0);
        check("zero_busy_seen", busy_seen, 0);
        check("zero_done_cnt", done_cnt, 1);

        // Abort during the 10th high phase; start/params dropped mid-move
        run_move(100, 0, 200, 200, 0, 1'b1, 10, 0, 5000);
        check("abort_pulses", rises.size(), 10);
        check("abort_steps_done", steps_done, 10);
        check("abort_last_period", (rises.size() > 0 && done_cyc >= 0) ? done_cyc - rises[rises.size()-1] : -1, 200);
        check("abort_position", position, pexp(-12));
        check("abort_done_cnt", done_cnt, 1);

        // Asynchronous reset mid-LO, then a fresh full move
        run_move(50, 0, 200, 200, 0, 1'b1, 0, 3, 5000);
        run_move(8, 0, 200, 200, 0, 1'b1, 0, 0, 5000);
        push_n(200, 8);
        check_periods("post_rst");
        check("post_rst_steps_done", steps_done, 8);
        check("post_rst_position", position, pexp(8));

`ifdef STEP_POSITION_EN
        @(negedge clk); #1 set_pos = 1; pos_value = 32'd1000;
        @(negedge clk); #1 set_pos = 0;
        check("set_pos", position, 1000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
